// File: rtl/m_axis_s2mm_pktgen.sv
// m_axis_s2mm_pktgen
// Drains a first-word-fall-through sample FIFO onto an AXI4-Stream master
// (DMA S2MM side) in packets of run-time programmable length, TLAST on the
// final data beat, one beat per clock, fully registered output stage.
// Optional header beat before each packet: define M_AXIS_S2MM_HDR_EN.
module m_axis_s2mm_pktgen #(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M_START_COUNT      = 32,
    parameter int unsigned C_MAX_PKT_LEN        = 4096,
    parameter int unsigned C_PKT_CNT_WIDTH      = 16
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic                                ENABLE,
    input  logic [$clog2(C_MAX_PKT_LEN+1):0]    PKT_LEN,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     FIFO_DATA,
    input  logic                                FIFO_EMPTY,
    output logic                                FIFO_RD_EN,
    output logic                                BUSY,
    output logic [C_PKT_CNT_WIDTH-1:0]          PKT_CNT,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int unsigned LEN_W  = $clog2(C_MAX_PKT_LEN + 1) + 1;
    localparam int unsigned WAIT_W = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (C_M_START_COUNT > 0) ? WAIT_W'(C_M_START_COUNT - 1) : '0;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(C_MAX_PKT_LEN);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ARM,
        ST_HDR,
        ST_SEND
    } state_t;

    state_t                              state_q, state_d;
    logic [WAIT_W-1:0]                   wait_cnt_q, wait_cnt_d;
    logic [LEN_W-1:0]                    len_q, len_d;
    logic [LEN_W-1:0]                    beat_q, beat_d;
    logic [C_PKT_CNT_WIDTH-1:0]          pkt_cnt_q, pkt_cnt_d;
    logic                                tvalid_q, tvalid_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic                                tlast_q, tlast_d;
    logic                                rd_en;
    logic                                accept;
    logic [LEN_W-1:0]                    len_new;
`ifdef M_AXIS_S2MM_HDR_EN
    logic [31:0]                         hdr_word;
`endif

    // State, counters and output register
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            pkt_cnt_q  <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
        end
    end

    // Next-state, FIFO pop and output-register load decisions
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        len_d      = len_q;
        beat_d     = beat_q;
        pkt_cnt_d  = pkt_cnt_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        rd_en      = 1'b0;

        accept  = tvalid_q && M_AXIS_TREADY;
        len_new = (PKT_LEN > MAX_LEN) ? MAX_LEN : PKT_LEN;
`ifdef M_AXIS_S2MM_HDR_EN
        hdr_word = {16'(pkt_cnt_q), 16'(len_new)};
`endif

        // A consumed beat frees the register; a load below overrides this.
        if (accept) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ARM;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ARM: begin
                if (ENABLE && (PKT_LEN != '0)) begin
                    len_d  = len_new;
                    beat_d = '0;
`ifdef M_AXIS_S2MM_HDR_EN
                    // Header goes straight into the (idle) output register.
                    tvalid_d = 1'b1;
                    tdata_d  = C_M_AXIS_TDATA_WIDTH'(hdr_word);
                    tlast_d  = 1'b0;
                    state_d  = ST_HDR;
`else
                    state_d  = ST_SEND;
`endif
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                rd_en = !FIFO_EMPTY && (beat_q < len_q) && (!tvalid_q || M_AXIS_TREADY);
                if (rd_en) begin
                    tvalid_d = 1'b1;
                    tdata_d  = FIFO_DATA;
                    tlast_d  = (beat_q == len_q - LEN_W'(1));
                    beat_d   = beat_q + LEN_W'(1);
                end
                if (accept && tlast_q) begin
                    state_d   = ST_ARM;
                    pkt_cnt_d = pkt_cnt_q + C_PKT_CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign FIFO_RD_EN    = rd_en;
    assign BUSY          = (state_q == ST_SEND) || (state_q == ST_HDR);
    assign PKT_CNT       = pkt_cnt_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = tlast_q;

endmodule
